serial_adder: RTL and testbench
===============================

SERIAL_ADDER -- requirements
Module: serial_adder

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the operand width in bits (legal range 2..32).
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-004 The block SHALL have port start, input, 1 bit: request to begin an addition, sampled on the clk rising edge.
REQ-005 The block SHALL have port A, input, WIDTH bits: minuend-side operand (augend), unsigned.
REQ-006 The block SHALL have port B, input, WIDTH bits: addend, unsigned.
REQ-007 The block SHALL have port Cin, input, 1 bit: carry-in.
REQ-008 The block SHALL have port busy, output, 1 bit: high while an addition is in progress.
REQ-009 The block SHALL have port done, output, 1 bit: one-cycle pulse marking result valid.
REQ-010 The block SHALL have port S, output, WIDTH bits: sum, registered.
REQ-011 The block SHALL have port Co, output, 1 bit: carry-out, registered.

Function
REQ-012 The block SHALL compute {Co,S} = A + B + Cin, modulo 2^(WIDTH+1), using one 1-bit full-adder cell and a carry flip-flop, processing bits LSB first.
REQ-013 The FSM SHALL have states IDLE, SHIFT, DONE; reset state IDLE.
REQ-014 IDLE: when start=1 at a rising edge, A, B, Cin SHALL be latched into internal shift/carry registers, the bit counter cleared, and the state SHALL go to SHIFT.
REQ-015 SHIFT: each cycle SHALL add one bit pair plus stored carry, shift the sum bit into the result register MSB-side, update carry, increment counter; after exactly WIDTH SHIFT cycles the state SHALL go to DONE.
REQ-016 DONE: S and Co SHALL be loaded from the result register/carry flip-flop at entry; done SHALL be high for exactly this one cycle; next state IDLE unconditionally.
REQ-017 busy SHALL be high in SHIFT only (exactly WIDTH cycles per operation); done SHALL be high in DONE only; busy and done SHALL never be high together.
REQ-018 Latency: with start sampled at edge k, done SHALL be high in the cycle following edge k+WIDTH+1, and S/Co SHALL be valid in that same cycle.
REQ-019 S and Co SHALL hold their last result from DONE until the next DONE; they SHALL NOT change during SHIFT.
REQ-020 start SHALL be ignored in SHIFT and DONE; changes on A, B, Cin after the latching edge SHALL NOT affect the result.
REQ-021 start held high continuously SHALL yield back-to-back operations with one IDLE cycle between DONE and the next SHIFT.
REQ-022 Carry out of bit WIDTH-1 SHALL appear only on Co; S SHALL wrap modulo 2^WIDTH.

Reset
REQ-023 rst_n=0 SHALL asynchronously force state IDLE, busy=0, done=0, S=0, Co=0, counter, shift registers and carry flip-flop to 0.
REQ-024 Reset asserted mid-SHIFT SHALL abort the operation; no done pulse SHALL follow, and S/Co SHALL read 0.
REQ-025 After rst_n deasserts, the first rising edge with start=1 SHALL be accepted normally.

Configuration
REQ-026 Macro SERIAL_ADDER_OVF_EN, when defined, SHALL add output port V, 1 bit, registered: signed (two's-complement) overflow = carry into MSB XOR carry out of MSB, updated in DONE with S/Co, reset to 0, held otherwise.
REQ-027 Without SERIAL_ADDER_OVF_EN, port V and its logic SHALL be absent and all other behaviour SHALL be identical.

Verification
REQ-028 Reset: rst_n=0 with A=8'hFF, B=8'hFF, start=1 -> busy=0, done=0, S=8'h00, Co=0 throughout.
REQ-029 Basic: WIDTH=8, A=8'h35, B=8'h1A, Cin=0, start pulse -> busy high 8 cycles, then done for 1 cycle with S=8'h4F, Co=0.
REQ-030 Carry/wrap: A=8'hFF, B=8'h01, Cin=1 -> S=8'h01, Co=1; with SERIAL_ADDER_OVF_EN, A=8'h7F, B=8'h01, Cin=0 -> S=8'h80, Co=0, V=1.
REQ-031 Ignore/hold: start re-pulsed and A/B changed to 8'h00 during SHIFT of 8'h35+8'h1A -> result still S=8'h4F; S unchanged until next DONE.
REQ-032 Abort: rst_n pulsed low on 4th SHIFT cycle -> no done pulse, S=0, Co=0; next start with A=8'h10, B=8'h20 -> S=8'h30.
REQ-033 Exhaustive: WIDTH=2, all 32 combinations of A, B, Cin with start held high -> every {Co,S} equals A+B+Cin, one IDLE cycle between operations.

Source files
------------

// File: rtl/serial_adder.sv
// Bit-serial adder: one full-adder cell and a carry flip-flop, LSB first, {Co,S} = A + B + Cin.
// Optional macro SERIAL_ADDER_OVF_EN adds the registered signed-overflow output V.
module serial_adder #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] S,
    output logic             Co
`ifdef SERIAL_ADDER_OVF_EN
    ,
    output logic             V
`endif
);

    localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_res;
    logic             r_carry;
    logic [CNT_W-1:0] r_cnt;
    logic             r_busy;
    logic             r_done;
    logic [WIDTH-1:0] r_s;
    logic             r_co;
    logic             w_sum;
    logic             w_cout;
    logic             w_last;

    // Single full-adder cell on the current LSBs plus the stored carry
    assign w_sum  = r_a[0] ^ r_b[0] ^ r_carry;
    assign w_cout = (r_a[0] & r_b[0]) | (r_carry & (r_a[0] ^ r_b[0]));
    assign w_last = (r_cnt == CNT_W'(WIDTH - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (start) w_next = SHIFT;
            SHIFT:   if (w_last) w_next = DONE;
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Operand shifters, result shifter, carry and bit counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a     <= '0;
            r_b     <= '0;
            r_res   <= '0;
            r_carry <= 1'b0;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_a     <= A;
                        r_b     <= B;
                        r_carry <= Cin;
                        r_cnt   <= '0;
                    end
                end
                SHIFT: begin
                    r_a     <= {1'b0, r_a[WIDTH-1:1]};
                    r_b     <= {1'b0, r_b[WIDTH-1:1]};
                    r_res   <= {w_sum, r_res[WIDTH-1:1]};
                    r_carry <= w_cout;
                    r_cnt   <= r_cnt + CNT_W'(1);
                end
                default: ;
            endcase
        end
    end

    // Registered status and result; status tracks the state one cycle behind
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_busy <= 1'b0;
            r_done <= 1'b0;
            r_s    <= '0;
            r_co   <= 1'b0;
        end else begin
            r_busy <= (r_state == SHIFT);
            r_done <= (r_state == DONE);
            if (r_state == DONE) begin
                r_s  <= r_res;
                r_co <= r_carry;
            end
        end
    end

    assign busy = r_busy;
    assign done = r_done;
    assign S    = r_s;
    assign Co   = r_co;

`ifdef SERIAL_ADDER_OVF_EN
    logic r_cmsb;
    logic r_v;

    // Capture the carry into the MSB so overflow can be formed at DONE
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cmsb <= 1'b0;
            r_v    <= 1'b0;
        end else begin
            if (r_state == SHIFT && w_last) r_cmsb <= r_carry;
            if (r_state == DONE) r_v <= r_cmsb ^ r_carry;
        end
    end

    assign V = r_v;
`endif

endmodule

// File: tb/tb_serial_adder.sv
// Directed self-checking bench for serial_adder: an 8-bit instance for the functional cases
// and a 2-bit instance swept over every operand combination with start held high.
module tb_serial_adder;

    logic       clk = 1'b0;
    logic       rst_n;

    logic       start;
    logic [7:0] A;
    logic [7:0] B;
    logic       Cin;
    logic       busy;
    logic       done;
    logic [7:0] S;
    logic       Co;

    logic       start2;
    logic [1:0] a2;
    logic [1:0] b2;
    logic       cin2;
    logic       busy2;
    logic       done2;
    logic [1:0] s2;
    logic       co2;

`ifdef SERIAL_ADDER_OVF_EN
    logic       V;
    logic       v2;
`endif

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    serial_adder #(.WIDTH(8)) u_dut8 (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .A     (A),
        .B     (B),
        .Cin   (Cin),
        .busy  (busy),
        .done  (done),
        .S     (S),
        .Co    (Co)
`ifdef SERIAL_ADDER_OVF_EN
        ,
        .V     (V)
`endif
    );

    serial_adder #(.WIDTH(2)) u_dut2 (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start2),
        .A     (a2),
        .B     (b2),
        .Cin   (cin2),
        .busy  (busy2),
        .done  (done2),
        .S     (s2),
        .Co    (co2)
`ifdef SERIAL_ADDER_OVF_EN
        ,
        .V     (v2)
`endif
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // One 8-bit operation; optionally disturbs start and operands during SHIFT
    task automatic run8(input string tag, input logic [7:0] a, input logic [7:0] b,
                        input logic cin, input logic [7:0] es, input logic eco,
                        input logic disturb);
        logic [7:0] hold_s;
        logic       hold_co;
        int         nb;
        int         nd;
        int         changed;
        A     = a;
        B     = b;
        Cin   = cin;
        start = 1'b1;
        tick();
        start   = 1'b0;
        hold_s  = S;
        hold_co = Co;
        nb      = 0;
        nd      = 0;
        changed = 0;
        for (int i = 0; i < 8; i++) begin
            if (disturb && i == 2) begin
                start = 1'b1;
                A     = 8'h00;
                B     = 8'h00;
                Cin   = 1'b0;
            end
            if (disturb && i == 4) start = 1'b0;
            tick();
            nb += int'(busy);
            nd += int'(done);
            if (S !== hold_s || Co !== hold_co) changed++;
        end
        check({tag, " busy cycles"}, 32'(nb), 32'd8);
        check({tag, " early done"}, 32'(nd), 32'd0);
        check({tag, " S held in SHIFT"}, 32'(changed), 32'd0);
        tick();
        check({tag, " done/busy"}, 32'({done, busy}), 32'b10);
        check({tag, " {Co,S}"}, 32'({Co, S}), 32'({eco, es}));
        tick();
        check({tag, " done pulse width"}, 32'(done), 32'd0);
    endtask

    initial begin
        logic [7:0] pattern;
        logic       gb;
        logic       gd;
        logic       b1;
        logic       b2v;
        int         ndone;
        int         ea;
        int         eb;
        int         ec;

        rst_n  = 1'b0;
        start  = 1'b1;
        A      = 8'hFF;
        B      = 8'hFF;
        Cin    = 1'b1;
        start2 = 1'b0;
        a2     = 2'b00;
        b2     = 2'b00;
        cin2   = 1'b0;
        #1;
        check("reset initial", 32'({busy, done, Co, S}), 32'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("reset held", 32'({busy, done, Co, S}), 32'd0);
        end
        start = 1'b0;
        rst_n = 1'b1;

        run8("basic", 8'h35, 8'h1A, 1'b0, 8'h4F, 1'b0, 1'b0);
`ifdef SERIAL_ADDER_OVF_EN
        check("basic V", 32'(V), 32'd0);
`endif
        run8("wrap", 8'hFF, 8'h01, 1'b1, 8'h01, 1'b1, 1'b0);
        run8("max", 8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0);
        run8("ovf", 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b0);
`ifdef SERIAL_ADDER_OVF_EN
        check("ovf V", 32'(V), 32'd1);
`endif
        run8("ignore", 8'h35, 8'h1A, 1'b0, 8'h4F, 1'b0, 1'b1);
        repeat (3) tick();
        check("hold after done", 32'({Co, S}), 32'h04F);

        // Abort during the fourth SHIFT cycle
        A     = 8'h35;
        B     = 8'h1A;
        Cin   = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (3) tick();
        rst_n = 1'b0;
        #1;
        check("abort clears", 32'({busy, done, Co, S}), 32'd0);
        tick();
        rst_n = 1'b1;
        ndone = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            ndone += int'(done);
        end
        check("abort no done", 32'(ndone), 32'd0);
        check("abort S/Co", 32'({Co, S}), 32'd0);
        run8("after abort", 8'h10, 8'h20, 1'b0, 8'h30, 1'b0, 1'b0);

        // 2-bit sweep, start held high: gap, busy, busy, done every four cycles
        start2        = 1'b1;
        {a2, b2, cin2} = 5'd0;
        for (int n = 0; n < 32; n++) begin
            tick();
            gb = busy2;
            gd = done2;
            {a2, b2, cin2} = 5'(n + 1);
            tick();
            b1 = busy2;
            pattern[5] = done2;
            tick();
            b2v = busy2;
            pattern[3] = done2;
            tick();
            pattern = {gb, gd, b1, pattern[5], b2v, pattern[3], done2, busy2};
            check($sformatf("sweep %0d timing", n), 32'(pattern), 32'b00_10_10_10);
            ea = (n >> 3) & 3;
            eb = (n >> 1) & 3;
            ec = n & 1;
            check($sformatf("sweep %0d {Co,S}", n), 32'({co2, s2}), 32'(ea + eb + ec));
        end
        start2 = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
